// File: rtl/noc_pkg.sv
// -----------------------------------------------------------------------------
// noc_pkg
// Shared constants and helpers for the NoC input port and its FIFO.
//   STALL_CNT_W : width of the optional stall counter
//   dest_w()    : destination field width for a given crossbar port count
//   dest_msb()  : bit position of the destination field MSB in a flit header
// -----------------------------------------------------------------------------
package noc_pkg;

  localparam int STALL_CNT_W = 16;

  // A one-port crossbar still gets a 1-bit field so port widths never collapse.
  function automatic int dest_w(input int ports);
    return (ports > 1) ? $clog2(ports) : 1;
  endfunction

  // The destination field sits at the top of the flit.
  function automatic int dest_msb(input int width);
    return width - 1;
  endfunction

endpackage

// File: rtl/noc_sync_fifo.sv
// -----------------------------------------------------------------------------
// noc_sync_fifo
// Single-clock FIFO with registered count and combinational head read.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   push, wdata     : write strobe and data (ignored while full)
//   pop             : read strobe (ignored while empty)
//   rdata           : current head entry (valid while !empty)
//   full, empty     : status decoded from the registered count
//   count           : entries in use, 0..DEPTH
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module noc_sync_fifo
  import noc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  // A push at full is refused even if a pop frees a slot in the same cycle.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // Storage carries no reset; only pointers/count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/noc_input_port.sv
// -----------------------------------------------------------------------------
// noc_input_port
// Ingress stage for one crossbar input: FIFO -> staging register -> crossbar.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   in_valid_i/in_data_i/in_ready_o : upstream link, flit accepted when
//                       in_valid_i & in_ready_o at a rising edge
//   xb_data_o/xb_dest_o/xb_dest_en_o : request to the crossbar
//   xb_ack_i, xb_bp_i : grant and destination backpressure from the crossbar
//   drop_o            : one-cycle pulse when a flit with an illegal dest is
//                       discarded (only possible when PORTS is not 2**n)
//   occupancy_o       : FIFO entries in use (staging excluded)
//   stall_cnt_o       : saturating count of stalled request cycles
// Handshakes: upstream is valid/ready -- a flit moves only on a cycle where
// valid and ready are both high, and ready depends only on registered state.
// Downstream, xb_dest_en_o is the valid; data/dest stay frozen until a cycle
// with xb_ack_i high and xb_bp_i all zero, which is the transfer.
// Build option: define NOC_INPUT_STALL_CNT_EN to build the stall counter;
// otherwise stall_cnt_o is constant 0.
// -----------------------------------------------------------------------------
module noc_input_port
  import noc_pkg::*;
#(
  parameter int PORTS    = 2,
  parameter int WIDTH    = 8,
  parameter int BP_WIDTH = 1,
  parameter int DEPTH    = 4,
  localparam int DEST_W  = dest_w(PORTS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid_i,
  input  logic [WIDTH-1:0]       in_data_i,
  output logic                   in_ready_o,
  output logic [WIDTH-1:0]       xb_data_o,
  output logic [DEST_W-1:0]      xb_dest_o,
  output logic                   xb_dest_en_o,
  input  logic                   xb_ack_i,
  input  logic [BP_WIDTH-1:0]    xb_bp_i,
  output logic                   drop_o,
  output logic [$clog2(DEPTH):0] occupancy_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
);

  localparam int DMSB = dest_msb(WIDTH);
  // PORTS fits in DEST_W+1 bits, so the legality compare needs one extra bit.
  localparam logic [DEST_W:0] PORTS_LIM = (DEST_W+1)'(PORTS);

  logic              fifo_full;
  logic              fifo_empty;
  logic [WIDTH-1:0]  head;
  logic [DEST_W-1:0] head_dest;
  logic              head_illegal;
  logic              push;
  logic              pop;
  logic              load;
  logic              transfer;

  logic              stg_valid;
  logic [WIDTH-1:0]  stg_data;
  logic [DEST_W-1:0] stg_dest;

  // rst_n is folded in so the link sees not-ready while reset is held,
  // even though the cleared count alone would read as "space available".
  assign in_ready_o   = rst_n & ~fifo_full;
  assign push         = in_valid_i & in_ready_o;

  assign head_dest    = head[DMSB -: DEST_W];
  assign head_illegal = ({1'b0, head_dest} >= PORTS_LIM);

  assign transfer     = stg_valid & xb_ack_i & ~(|xb_bp_i);
  // Pop whenever staging is free or being freed; an illegal head is popped
  // but not loaded, so staging keeps whatever it would otherwise have.
  assign pop          = ~fifo_empty & (~stg_valid | transfer);
  assign load         = pop & ~head_illegal;

  noc_sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (in_data_i),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (occupancy_o)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_valid <= 1'b0;
      stg_data  <= '0;
      stg_dest  <= '0;
      drop_o    <= 1'b0;
    end else begin
      if (load) begin
        stg_valid <= 1'b1;
        stg_data  <= head;
        stg_dest  <= head_dest;
      end else if (transfer) begin
        stg_valid <= 1'b0;
      end
      drop_o <= pop & head_illegal;
    end
  end

  assign xb_dest_en_o = stg_valid;
  assign xb_data_o    = stg_data;
  assign xb_dest_o    = stg_dest;

`ifdef NOC_INPUT_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stg_valid && !transfer && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign stall_cnt_o = stall_cnt;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_noc_input_port.sv
// -----------------------------------------------------------------------------
// tb_noc_input_port
// Bench for noc_input_port: a PORTS=2 instance for the main traffic cases and
// a PORTS=3 instance for illegal-destination dropping. Accepted flits are
// queued at the upstream handshake and checked in order at each transfer.
// -----------------------------------------------------------------------------
module tb_noc_input_port;

`ifdef NOC_INPUT_STALL_CNT_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- PORTS=2 instance ----------------
  logic        in_valid = 1'b0;
  logic [7:0]  in_data  = '0;
  logic        in_ready;
  logic [7:0]  xb_data;
  logic [0:0]  xb_dest;
  logic        xb_dest_en;
  logic        xb_ack = 1'b0;
  logic [0:0]  xb_bp  = '0;
  logic        drop;
  logic [2:0]  occ;
  logic [15:0] stall_cnt;

  noc_input_port #(.PORTS(2), .WIDTH(8), .BP_WIDTH(1), .DEPTH(4)) u_dut (
    .clk (clk), .rst_n (rst_n),
    .in_valid_i (in_valid), .in_data_i (in_data), .in_ready_o (in_ready),
    .xb_data_o (xb_data), .xb_dest_o (xb_dest), .xb_dest_en_o (xb_dest_en),
    .xb_ack_i (xb_ack), .xb_bp_i (xb_bp), .drop_o (drop),
    .occupancy_o (occ), .stall_cnt_o (stall_cnt)
  );

  // ---------------- PORTS=3 instance ----------------
  logic        in_valid3 = 1'b0;
  logic [7:0]  in_data3  = '0;
  logic        in_ready3;
  logic [7:0]  xb_data3;
  logic [1:0]  xb_dest3;
  logic        xb_dest_en3;
  logic        xb_ack3 = 1'b0;
  logic [0:0]  xb_bp3  = '0;
  logic        drop3;
  logic [2:0]  occ3;
  logic [15:0] stall_cnt3;

  noc_input_port #(.PORTS(3), .WIDTH(8), .BP_WIDTH(1), .DEPTH(4)) u_dut3 (
    .clk (clk), .rst_n (rst_n),
    .in_valid_i (in_valid3), .in_data_i (in_data3), .in_ready_o (in_ready3),
    .xb_data_o (xb_data3), .xb_dest_o (xb_dest3), .xb_dest_en_o (xb_dest_en3),
    .xb_ack_i (xb_ack3), .xb_bp_i (xb_bp3), .drop_o (drop3),
    .occupancy_o (occ3), .stall_cnt_o (stall_cnt3)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp3_q[$];
  int xfer_cnt  = 0;
  int xfer3_cnt = 0;
  int drop_cnt  = 0;
  int drop3_cnt = 0;
  int exp_drop3 = 0;
  int exp_stall = 0;
  bit rnd_mode  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Monitors sample on the falling edge: values seen here are what the
  // next rising edge will act on.
  always @(negedge clk) begin
    logic [7:0] e;
    if (!rst_n) begin
      exp_q.delete();
      exp3_q.delete();
      exp_stall = 0;
    end else begin
      // PORTS=2 instance
      if (in_valid && in_ready) exp_q.push_back(in_data);
      if (xb_dest_en && xb_ack && !(|xb_bp)) begin
        xfer_cnt++;
        check("xfer_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("xfer_data", 32'(xb_data), 32'(e));
          check("xfer_dest", 32'(xb_dest), 32'(e[7]));
        end
      end else if (xb_dest_en) begin
        exp_stall++;
      end
      if (drop) drop_cnt++;
      // PORTS=3 instance: header values 3 are not a legal port
      if (in_valid3 && in_ready3) begin
        if (in_data3[7:6] >= 2'd3) exp_drop3++;
        else exp3_q.push_back(in_data3);
      end
      if (xb_dest_en3 && xb_ack3 && !(|xb_bp3)) begin
        xfer3_cnt++;
        check("xfer3_expected", 32'(exp3_q.size() != 0), 32'd1);
        if (exp3_q.size() != 0) begin
          e = exp3_q.pop_front();
          check("xfer3_data", 32'(xb_data3), 32'(e));
          check("xfer3_dest", 32'(xb_dest3), 32'(e[7:6]));
        end
      end
      if (drop3) drop3_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_mode) begin
      xb_ack = 1'($urandom_range(0, 1));
      xb_bp  = 1'($urandom_range(0, 3) == 0);
    end
  endtask

  task automatic push_flit(input logic [7:0] d);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    check("push_wait", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int accepted;
    int base;
    int n;

    // Reset values while rst_n is held low
    #3;
    check("rst_ready",   32'(in_ready),   32'd0);
    check("rst_dest_en", 32'(xb_dest_en), 32'd0);
    check("rst_data",    32'(xb_data),    32'd0);
    check("rst_dest",    32'(xb_dest),    32'd0);
    check("rst_occ",     32'(occ),        32'd0);
    check("rst_drop",    32'(drop),       32'd0);
    check("rst_stall",   32'(stall_cnt),  32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    tick();
    check("idle_ready", 32'(in_ready), 32'd1);

    // Single flit, dest 1, continuous grant
    xb_ack = 1'b1; xb_bp = 1'b0;
    in_valid = 1'b1; in_data = 8'h80;
    tick();
    in_valid = 1'b0;
    check("single_occ1",   32'(occ),        32'd1);
    check("single_en0",    32'(xb_dest_en), 32'd0);
    tick();
    check("single_en1",    32'(xb_dest_en), 32'd1);
    check("single_dest",   32'(xb_dest),    32'd1);
    check("single_data",   32'(xb_data),    32'h80);
    check("single_occ0",   32'(occ),        32'd0);
    tick();
    check("single_en_off", 32'(xb_dest_en), 32'd0);

    // Backpressure for 5 cycles, then release
    xb_bp = 1'b1;
    in_valid = 1'b1; in_data = 8'h05;
    tick();
    in_valid = 1'b0;
    tick();
    for (int k = 0; k < 5; k++) begin
      check("bp_hold_en",   32'(xb_dest_en), 32'd1);
      check("bp_hold_data", 32'(xb_data),    32'h05);
      check("bp_hold_dest", 32'(xb_dest),    32'd0);
      tick();
    end
    xb_bp = 1'b0;
    check("bp_last_en", 32'(xb_dest_en), 32'd1);
    tick();
    check("bp_done_en", 32'(xb_dest_en), 32'd0);
    check("bp_stall",   32'(stall_cnt),  STALL_EN ? 32'd5 : 32'd0);

    // Fill with no grant: 6 offers, 5 fit (4 FIFO + 1 staging)
    xb_ack = 1'b0;
    accepted = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h10 + i);
      if (in_ready) accepted++;
      tick();
    end
    in_valid = 1'b0;
    check("fill_accepted", 32'(accepted),   32'd5);
    check("fill_ready",    32'(in_ready),   32'd0);
    check("fill_occ",      32'(occ),        32'd4);
    check("fill_stg_data", 32'(xb_data),    32'h10);

    // Full with a simultaneous pop: the push must wait one cycle
    in_valid = 1'b1; in_data = 8'h20;
    xb_ack = 1'b1;
    base = xfer_cnt;
    check("full_ready", 32'(in_ready), 32'd0);
    tick();
    check("full_pop_occ",   32'(occ),      32'd3);
    check("full_ready_ret", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    check("drain_xfers", 32'(xfer_cnt - base), 32'd6);
    check("drain_en",    32'(xb_dest_en),      32'd0);
    check("drain_occ",   32'(occ),             32'd0);
    check("drain_stall", 32'(stall_cnt),       STALL_EN ? 32'(exp_stall) : 32'd0);

    // Random burst with random grant/backpressure
    rnd_mode = 1'b1;
    for (int i = 0; i < 20; i++) push_flit(8'($urandom_range(0, 255)));
    rnd_mode = 1'b0;
    xb_ack = 1'b1; xb_bp = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    check("burst_drain", 32'(exp_q.size()), 32'd0);
    tick();
    check("burst_en",    32'(xb_dest_en), 32'd0);
    check("burst_stall", 32'(stall_cnt),  STALL_EN ? 32'(exp_stall) : 32'd0);

    // Illegal destination on the PORTS=3 instance
    xb_ack3 = 1'b1; xb_bp3 = 1'b0;
    in_valid3 = 1'b1; in_data3 = 8'hC0;
    tick();
    in_data3 = 8'h40;
    tick();
    in_valid3 = 1'b0;
    check("ill_drop_pulse", 32'(drop3), 32'd1);
    tick();
    check("ill_drop_clear", 32'(drop3),      32'd0);
    check("ill_req",        32'(xb_dest_en3), 32'd1);
    check("ill_req_data",   32'(xb_data3),   32'h40);
    check("ill_req_dest",   32'(xb_dest3),   32'd1);
    repeat (3) tick();
    check("ill_drop_cnt",  32'(drop3_cnt), 32'd1);
    check("ill_drop_exp",  32'(drop3_cnt), 32'(exp_drop3));
    check("ill_xfer_cnt",  32'(xfer3_cnt), 32'd1);
    check("ill_occ",       32'(occ3),      32'd0);

    // Reset in the middle of traffic
    xb_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h30 + i);
      tick();
    end
    in_valid = 1'b0;
    check("mid_occ", 32'(occ),        32'd3);
    check("mid_en",  32'(xb_dest_en), 32'd1);
    base = xfer_cnt;
    #2 rst_n = 1'b0;
    #1;
    check("async_en",    32'(xb_dest_en), 32'd0);
    check("async_occ",   32'(occ),        32'd0);
    check("async_ready", 32'(in_ready),   32'd0);
    check("async_data",  32'(xb_data),    32'd0);
    check("async_stall", 32'(stall_cnt),  32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    xb_ack = 1'b1;
    repeat (6) tick();
    check("post_rst_en",   32'(xb_dest_en),      32'd0);
    check("post_rst_occ",  32'(occ),             32'd0);
    check("post_rst_xfer", 32'(xfer_cnt - base), 32'd0);
    check("no_drop_p2",    32'(drop_cnt),        32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
